// File: rtl/cache_trace_frontend_pkg.sv
// Shared types for the L1 trace frontend: command encoding, request record
// and the address split geometry.
package cache_trace_frontend_pkg;

  localparam int ADDRESS_BITS = 32;
  localparam int OFFSET_BITS  = 6;
  localparam int INDEX_BITS   = 14;
  localparam int TAG_BITS     = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS;

  typedef enum logic [3:0] {
    CMD_READ       = 4'd0,
    CMD_WRITE      = 4'd1,
    CMD_IFETCH     = 4'd2,
    CMD_L2_INVAL   = 4'd3,
    CMD_L2_DATA_RQ = 4'd4,
    CMD_CLR        = 4'd8,
    CMD_PRINT      = 4'd9
  } cmd_e;

  typedef struct packed {
    cmd_e                    cmd;
    logic [ADDRESS_BITS-1:0] addr;
  } trace_req_t;

  function automatic logic is_legal_cmd(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cache_trace_frontend_req_fifo.sv
// In-order request FIFO; occupancy is tracked separately from the wrapping
// pointers so full and empty never alias.
module cache_req_fifo
  import cache_trace_frontend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  trace_req_t             push_data,
  input  logic                   pop,
  output trace_req_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;
  trace_req_t    mem_q [DEPTH];

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_q;
  // Head is read combinationally so a fresh entry is visible the next cycle.
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cache_trace_frontend.sv
// Trace command frontend: filters illegal codes, queues legal requests,
// issues them split into tag/index/offset and keeps saturating statistics.
module cache_trace_frontend
  import cache_trace_frontend_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_cmd,
  input  logic [ADDRESS_BITS-1:0] in_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_cmd,
  output logic [TAG_BITS-1:0]     out_tag,
  output logic [INDEX_BITS-1:0]   out_index,
  output logic [OFFSET_BITS-1:0]  out_offset,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [CNT_W-1:0]        read_cnt,
  output logic [CNT_W-1:0]        write_cnt,
  output logic [CNT_W-1:0]        fetch_cnt,
  output logic [CNT_W-1:0]        bad_cmd_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CLR} state_e;

  state_e           state_q, state_d;
  logic             full, empty, legal, in_fire, out_fire, push, clr;
  trace_req_t       push_req, head;
  logic [CNT_W-1:0] read_cnt_q, read_cnt_d, write_cnt_q, write_cnt_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d, bad_cnt_q, bad_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_ready  = !rst && !full && (state_q != S_CLR);
  assign in_fire   = in_valid && in_ready;
  assign legal     = is_legal_cmd(in_cmd);
  assign push      = in_fire && legal;
  assign push_req  = '{cmd: cmd_e'(in_cmd), addr: in_addr};
  assign out_valid = (state_q == S_ISSUE);
  assign out_fire  = out_valid && out_ready;
  assign clr       = (out_fire && head.cmd == CMD_CLR) || (state_q == S_CLR);

  cache_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_req),
    .pop       (out_fire),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // Fields read zero whenever nothing is being offered.
  always_comb begin
    out_cmd    = '0;
    out_tag    = '0;
    out_index  = '0;
    out_offset = '0;
    if (out_valid) begin
      out_cmd    = head.cmd;
      out_tag    = head.addr[ADDRESS_BITS-1 -: TAG_BITS];
      out_index  = head.addr[OFFSET_BITS +: INDEX_BITS];
      out_offset = head.addr[OFFSET_BITS-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (push) state_d = S_ISSUE;
      S_ISSUE: begin
        if (out_fire) begin
          if (head.cmd == CMD_CLR)                 state_d = S_CLR;
          else if (fifo_count > CW'(1) || push)    state_d = S_ISSUE;
          else                                     state_d = S_IDLE;
        end
      end
      S_CLR:   state_d = empty ? S_IDLE : S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    read_cnt_d  = read_cnt_q;
    write_cnt_d = write_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    if (out_fire) begin
      case (head.cmd)
        CMD_READ:   read_cnt_d  = sat_inc(read_cnt_q);
        CMD_WRITE:  write_cnt_d = sat_inc(write_cnt_q);
        CMD_IFETCH: fetch_cnt_d = sat_inc(fetch_cnt_q);
        default:    ;
      endcase
    end
    if (in_fire && !legal) bad_cnt_d = sat_inc(bad_cnt_q);
    // Clearing wins over any increment landing in the same cycle.
    if (clr) begin
      read_cnt_d  = '0;
      write_cnt_d = '0;
      fetch_cnt_d = '0;
      bad_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      read_cnt_q  <= '0;
      write_cnt_q <= '0;
      fetch_cnt_q <= '0;
      bad_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      read_cnt_q  <= read_cnt_d;
      write_cnt_q <= write_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign read_cnt    = read_cnt_q;
  assign write_cnt   = write_cnt_q;
  assign fetch_cnt   = fetch_cnt_q;
  assign bad_cmd_cnt = bad_cnt_q;

endmodule
